// File: rtl/mem_arbiter_pkg.sv
// Shared bus widths, FSM state encodings and the memory command bundle for mem_arbiter.
// The MEM_ARB_RR_EN build option is handled in mem_arb_req_mux and mem_arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_BUS = 32;
    localparam int unsigned DATA_BUS = 32;
    localparam int unsigned SEL_W    = DATA_BUS / 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_INST = 2'd1,
        ARB_DATA = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } arb_grant_e;

    typedef struct packed {
        logic                we;
        logic [SEL_W-1:0]    sel;
        logic [ADDR_BUS-1:0] addr;
        logic [DATA_BUS-1:0] wdata;
    } mem_cmd_t;

    // Fetches are always full-word reads.
    function automatic mem_cmd_t inst_cmd(input logic [ADDR_BUS-1:0] addr);
        mem_cmd_t c;
        c.we    = 1'b0;
        c.sel   = '1;
        c.addr  = addr;
        c.wdata = '0;
        return c;
    endfunction

endpackage

// File: rtl/mem_arb_req_mux.sv
// Picks the winning requester and muxes its command fields onto one bundle.
// MEM_ARB_RR_EN: conflicts go to the port not granted last; otherwise data always wins.
module mem_arb_req_mux
    import mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  arb_grant_e          last_grant_i,
`endif
    input  logic                inst_req_i,
    input  logic [ADDR_BUS-1:0] inst_addr_i,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [SEL_W-1:0]    data_sel_i,
    input  logic [ADDR_BUS-1:0] data_addr_i,
    input  logic [DATA_BUS-1:0] data_wdata_i,
    output logic                req_any_o,
    output arb_grant_e          winner_o,
    output mem_cmd_t            cmd_o
);

    mem_cmd_t data_cmd;

    always_comb begin
        data_cmd.we    = data_we_i;
        data_cmd.sel   = data_sel_i;
        data_cmd.addr  = data_addr_i;
        data_cmd.wdata = data_wdata_i;
    end

    always_comb begin
        req_any_o = inst_req_i | data_req_i;
        winner_o  = GNT_DATA;
        if (inst_req_i && data_req_i) begin
`ifdef MEM_ARB_RR_EN
            winner_o = (last_grant_i == GNT_DATA) ? GNT_INST : GNT_DATA;
`else
            winner_o = GNT_DATA;
`endif
        end else if (inst_req_i) begin
            winner_o = GNT_INST;
        end
        cmd_o = (winner_o == GNT_DATA) ? data_cmd : inst_cmd(inst_addr_i);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access; one grant at a time.
// Build option MEM_ARB_RR_EN selects round-robin conflict resolution (default: data first).
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_BUS-1:0] inst_addr,
    output logic [DATA_BUS-1:0] inst_rdata,
    output logic                inst_done,
    input  logic                data_req,
    input  logic                data_we,
    input  logic [SEL_W-1:0]    data_sel,
    input  logic [ADDR_BUS-1:0] data_addr,
    input  logic [DATA_BUS-1:0] data_wdata,
    output logic [DATA_BUS-1:0] data_rdata,
    output logic                data_done,
    output logic                mem_en,
    output logic                mem_we,
    output logic [SEL_W-1:0]    mem_sel,
    output logic [ADDR_BUS-1:0] mem_addr,
    output logic [DATA_BUS-1:0] mem_wdata,
    input  logic [DATA_BUS-1:0] mem_rdata,
    input  logic                mem_ready,
    output logic                stall
);

    arb_state_e          state_q,      state_d;
    logic                mem_en_q,     mem_en_d;
    mem_cmd_t            cmd_q,        cmd_d;
    logic [DATA_BUS-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_BUS-1:0] data_rdata_q, data_rdata_d;
    logic                inst_done_q,  inst_done_d;
    logic                data_done_q,  data_done_d;

    logic                req_any;
    arb_grant_e          winner;
    mem_cmd_t            mux_cmd;

`ifdef MEM_ARB_RR_EN
    arb_grant_e          last_grant_q, last_grant_d;
`endif

    mem_arb_req_mux u_req_mux (
`ifdef MEM_ARB_RR_EN
        .last_grant_i (last_grant_q),
`endif
        .inst_req_i   (inst_req),
        .inst_addr_i  (inst_addr),
        .data_req_i   (data_req),
        .data_we_i    (data_we),
        .data_sel_i   (data_sel),
        .data_addr_i  (data_addr),
        .data_wdata_i (data_wdata),
        .req_any_o    (req_any),
        .winner_o     (winner),
        .cmd_o        (mux_cmd)
    );

    always_comb begin
        state_d      = state_q;
        mem_en_d     = mem_en_q;
        cmd_d        = cmd_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_done_d  = 1'b0;
        data_done_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (req_any) begin
                    cmd_d    = mux_cmd;
                    mem_en_d = 1'b1;
                    state_d  = (winner == GNT_DATA) ? ARB_DATA : ARB_INST;
                end
            end
            ARB_INST: begin
                if (mem_ready) begin
                    inst_rdata_d = mem_rdata;
                    mem_en_d     = 1'b0;
                    inst_done_d  = 1'b1;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = GNT_INST;
`endif
                    state_d      = ARB_RESP;
                end
            end
            ARB_DATA: begin
                // Stores leave data_rdata untouched.
                if (mem_ready) begin
                    if (!cmd_q.we) begin
                        data_rdata_d = mem_rdata;
                    end
                    mem_en_d     = 1'b0;
                    data_done_d  = 1'b1;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = GNT_DATA;
`endif
                    state_d      = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            mem_en_q     <= 1'b0;
            cmd_q        <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= GNT_INST;
`endif
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            cmd_q        <= cmd_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = cmd_q.we;
    assign mem_sel    = cmd_q.sel;
    assign mem_addr   = cmd_q.addr;
    assign mem_wdata  = cmd_q.wdata;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign inst_done  = inst_done_q;
    assign data_done  = data_done_q;
    assign stall      = (inst_req & ~inst_done_q) | (data_req & ~data_done_q);

    done_onehot: assert property (@(posedge clk) disable iff (rst)
        !(inst_done_q && data_done_q));

    en_only_in_access: assert property (@(posedge clk) disable iff (rst)
        mem_en_q |-> (state_q == ARB_INST || state_q == ARB_DATA));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions, a monitor pops on done.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_sel;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_done  (inst_done),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_sel   (data_sel),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_done  (data_done),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_sel    (mem_sel),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   waits       = 0;
    bit   ready_always = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lookup(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h2408_0001;
            32'h0000_0104: return 32'h3C01_1000;
            32'h0000_3000: return 32'hCAFE_F00D;
            32'h0000_3004: return 32'h1357_9BDF;
            default:       return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic exp_t mk(input bit is_data, input logic [31:0] rdata);
        exp_t e;
        e.is_data = is_data;
        e.rdata   = rdata;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: answers mem_en after `waits` wait states.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (rst) begin
                wait_cnt = 0;
            end else if (ready_always) begin
                mem_ready = 1'b1;
                mem_rdata = lookup(mem_addr);
            end else if (mem_en) begin
                if (wait_cnt < waits) begin
                    wait_cnt++;
                end else begin
                    mem_ready = 1'b1;
                    mem_rdata = lookup(mem_addr);
                    wait_cnt  = 0;
                end
            end
        end
    end

    // Monitor: every done pulse must match the oldest expected completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && (inst_done === 1'b1 || data_done === 1'b1)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {30'b0, data_done, inst_done}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("done_port", {30'b0, data_done, inst_done}, e.is_data ? 32'h2 : 32'h1);
                    if (e.is_data) chk("data_rdata", data_rdata, e.rdata);
                    else           chk("inst_rdata", inst_rdata, e.rdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit is_data, input int maxc, output int done_cyc);
        bit seen;
        seen     = 1'b0;
        done_cyc = -100;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if ((is_data ? data_done : inst_done) === 1'b1) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!seen) begin
            if (is_data) chk("data_done_timeout", 32'h0, 32'h1);
            else         chk("inst_done_timeout", 32'h0, 32'h1);
        end
    endtask

    task automatic serve(input bit is_data, input int maxc, output int done_cyc);
        wait_done(is_data, maxc, done_cyc);
        @(posedge clk);
        #1;
        if (is_data) data_req = 1'b0;
        else         inst_req = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic conflict(input bit inst_first);
        int t0, dc, ic;
        step();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0104;
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_sel  = 4'hf;
        data_addr = 32'h0000_3000;
        t0 = cyc;
        if (inst_first) begin
            sb.push_back(mk(1'b0, 32'h3C01_1000));
            sb.push_back(mk(1'b1, 32'hCAFE_F00D));
        end else begin
            sb.push_back(mk(1'b1, 32'hCAFE_F00D));
            sb.push_back(mk(1'b0, 32'h3C01_1000));
        end
        fork
            serve(1'b1, 12, dc);
            serve(1'b0, 12, ic);
        join
        if (inst_first) begin
            chk("conflict_first_lat", ic - t0, 32'd2);
            chk("conflict_gap", dc - ic, 32'd3);
        end else begin
            chk("conflict_first_lat", dc - t0, 32'd2);
            chk("conflict_gap", ic - dc, 32'd3);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, dc;
        rst        = 1'b1;
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_sel   = '0;
        data_addr  = '0;
        data_wdata = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_inst_done", {31'b0, inst_done}, 32'h0);
        chk("rst_data_done", {31'b0, data_done}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_inst_rdata", inst_rdata, 32'h0);
        step();
        rst = 1'b0;

        // Instruction read, zero wait
        waits = 0;
        step();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0100;
        sb.push_back(mk(1'b0, 32'h2408_0001));
        @(negedge clk);
        chk("t1_c0_stall", {31'b0, stall}, 32'h1);
        chk("t1_c0_mem_en", {31'b0, mem_en}, 32'h0);
        @(negedge clk);
        chk("t1_c1_mem_en", {31'b0, mem_en}, 32'h1);
        chk("t1_c1_mem_addr", mem_addr, 32'h0000_0100);
        chk("t1_c1_mem_we", {31'b0, mem_we}, 32'h0);
        chk("t1_c1_mem_sel", {28'b0, mem_sel}, 32'hf);
        chk("t1_c1_stall", {31'b0, stall}, 32'h1);
        @(negedge clk);
        chk("t1_c2_inst_done", {31'b0, inst_done}, 32'h1);
        chk("t1_c2_stall", {31'b0, stall}, 32'h0);
        step();
        inst_req = 1'b0;
        @(negedge clk);
        chk("t1_c3_mem_en", {31'b0, mem_en}, 32'h0);
        chk("t1_c3_inst_done", {31'b0, inst_done}, 32'h0);

        // Data store, three wait states
        waits = 3;
        step();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_sel   = 4'b0011;
        data_addr  = 32'h0000_2000;
        data_wdata = 32'hDEAD_BEEF;
        t0 = cyc;
        sb.push_back(mk(1'b1, 32'h0));
        @(negedge clk);
        chk("t2_c0_mem_en", {31'b0, mem_en}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_hold_en", {31'b0, mem_en}, 32'h1);
            chk("t2_hold_we", {31'b0, mem_we}, 32'h1);
            chk("t2_hold_sel", {28'b0, mem_sel}, 32'h3);
            chk("t2_hold_addr", mem_addr, 32'h0000_2000);
            chk("t2_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("t2_hold_stall", {31'b0, stall}, 32'h1);
        end
        serve(1'b1, 3, dc);
        chk("t2_done_lat", dc - t0, 32'd5);

        // Store with no byte enables is still issued
        waits = 0;
        step();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_sel   = 4'b0000;
        data_addr  = 32'h0000_2008;
        data_wdata = 32'h0000_1234;
        sb.push_back(mk(1'b1, 32'h0));
        @(negedge clk);
        @(negedge clk);
        chk("sel0_mem_en", {31'b0, mem_en}, 32'h1);
        chk("sel0_mem_sel", {28'b0, mem_sel}, 32'h0);
        chk("sel0_mem_we", {31'b0, mem_we}, 32'h1);
        serve(1'b1, 4, dc);

        // Conflicts from a fresh reset: data wins twice, then a lone data read
        do_reset();
        conflict(1'b0);
        conflict(1'b0);
        step();
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_sel  = 4'hf;
        data_addr = 32'h0000_3004;
        sb.push_back(mk(1'b1, 32'h1357_9BDF));
        serve(1'b1, 6, dc);
`ifdef MEM_ARB_RR_EN
        conflict(1'b1);
`else
        conflict(1'b0);
`endif

        // Fetch withdrawn during wait states still completes once
        waits = 2;
        step();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0104;
        sb.push_back(mk(1'b0, 32'h3C01_1000));
        @(negedge clk);
        @(negedge clk);
        chk("wd_mem_en", {31'b0, mem_en}, 32'h1);
        step();
        inst_req = 1'b0;
        wait_done(1'b0, 8, dc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wd_no_regrant", {30'b0, mem_en, inst_done}, 32'h0);
        end

        // mem_ready outside an access is ignored
        waits = 0;
        ready_always = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rdy_idle_mem_en", {31'b0, mem_en}, 32'h0);
        end
        step();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0100;
        t0 = cyc;
        sb.push_back(mk(1'b0, 32'h2408_0001));
        serve(1'b0, 6, dc);
        chk("rdy_idle_lat", dc - t0, 32'd2);
        ready_always = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rdy_idle_after", {30'b0, mem_en, inst_done}, 32'h0);
        end

        // Reset while a data access waits; pending fetch then proceeds
        waits = 10;
        step();
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_sel  = 4'hf;
        data_addr = 32'h0000_3004;
        @(negedge clk);
        @(negedge clk);
        chk("ar_mem_en_before", {31'b0, mem_en}, 32'h1);
        step();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0100;
        #2;
        rst      = 1'b1;
        data_req = 1'b0;
        #1;
        chk("ar_mem_en", {31'b0, mem_en}, 32'h0);
        chk("ar_mem_we", {31'b0, mem_we}, 32'h0);
        chk("ar_done", {30'b0, data_done, inst_done}, 32'h0);
        chk("ar_mem_addr", mem_addr, 32'h0);
        chk("ar_data_rdata", data_rdata, 32'h0);
        chk("ar_inst_rdata", inst_rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst   = 1'b0;
        waits = 0;
        t0 = cyc;
        sb.push_back(mk(1'b0, 32'h2408_0001));
        serve(1'b0, 6, dc);
        chk("ar_regrant_lat", dc - t0, 32'd2);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
